c432_key_loader: RTL and testbench
==================================

# c432_key_loader

Sequential key-provisioning stage directly upstream of the locked c432 core. It receives the 10-bit unlock key bit-serially from the secure key store over a valid/ready handshake and checks an even-parity bit. On success it latches the key onto the core's K1..K10 inputs. Until a valid key is committed, the core's key inputs are held at all-zero. Repeated parity failures lock the loader out until reset.

## Interface
- `KEY_W`, default 10: number of key bits; equals the core's key input count.
- `MAX_FAILS`, default 3: number of parity failures that forces lockout, range 1..15.
---
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start_i`, input, 1: single-cycle request to begin a key frame.
- `bit_valid_i`, input, 1: serial bit is valid this cycle.
- `bit_i`, input, 1: serial key or parity bit.
- `bit_ready_o`, output, 1: loader accepts a bit this cycle.
- `key_o`, output, KEY_W: key to the core, with `key_o[0]` driving K1 and `key_o[KEY_W-1]` driving K10.
- `key_valid_o`, output, 1: a committed key is present on `key_o`.
- `busy_o`, output, 1: a frame is in progress.
- `err_o`, output, 1: the last frame failed parity. Sticky.
- `locked_o`, output, 1: lockout reached.

## Operation
**States:** IDLE, SHIFT, PARITY, DONE, LOCKOUT.

**Reset values:** state IDLE; `key_o`=0; all flags 0; bit counter 0; shadow register 0; fail counter 0.

**IDLE**
- `start_i`=1 → SHIFT. Clear the bit counter and the shadow register; clear `err_o`.

**SHIFT**
- Transfer when `bit_valid_i` && `bit_ready_o`.
- Bits arrive LSB first: the n-th accepted bit is written to `shadow[n]`.
- After bit KEY_W-1 is accepted → PARITY.

**PARITY**
- The next accepted bit is the parity bit `p`.
- If XOR(shadow) ^ `p` == 0 → DONE, and `key_o` <= shadow on the same edge.
- Otherwise → `err_o`=1 and the fail counter increments.
  - New count == MAX_FAILS → LOCKOUT.
  - Else → IDLE.
- The shadow register is cleared in both cases.

**DONE**
- Key is write-once per reset: `start_i` and bits are ignored, and `key_o` is held.

**LOCKOUT**
- `key_o` is forced to 0 and `locked_o`=1.
- All inputs are ignored. Only `rst` exits this state.

**Outputs are decoded from the registered state:**
- `bit_ready_o` = SHIFT or PARITY.
- `busy_o` = SHIFT or PARITY.
- `key_valid_o` = DONE.
- `locked_o` = LOCKOUT.

**Boundary cases:**
- `start_i` in SHIFT or PARITY aborts and restarts the frame: counter and shadow are cleared, and it does not count as a failure.
- `start_i` has priority over a simultaneous bit transfer.
- `bit_valid_i` in IDLE is ignored.
- The fail counter clears only on `rst`. A successful frame does not clear it.
- `rst` mid-frame returns every register to its reset value on the same assertion, with no clock edge needed.

## Timing
- `start_i` sampled at edge E → `bit_ready_o`=1 from the cycle after E.
- One bit per cycle maximum. Stalls on a low `bit_valid_i` are unbounded.
- Full frame is KEY_W+1 transfers.
- Parity bit accepted at edge P:
  - `key_o`, `key_valid_o`, or `err_o` / `locked_o` change at P.
  - Results are visible in the cycle after P.
  - `bit_ready_o` drops in that same cycle.
- Minimum start-to-valid latency: 1 + KEY_W + 1 edges = 12 edges at the defaults.
- `key_o` never shows partial shadow contents. It changes only at commit, at lockout, or at reset.

## Structure
- A shared package `c432_lock_pkg` holds:
  - the state enum `key_ld_state_t`;
  - the constants `C432_KEY_W`=10 and `C432_MAX_FAILS`=3, used for the parameter defaults.
- Single module with no sub-module. Contents:
  - bit counter of $clog2(KEY_W+1) bits;
  - KEY_W-bit shadow register;
  - running parity flop;
  - fail counter of 4 bits;
  - output key register.

## Test plan
- **Good frame:**
  - Stimulus: reset; `start_i`; then bits 0,1,0,1,0,0,1,1,0,1 followed by parity 1 (key 10'h2CA), with `bit_valid_i` held high.
  - Response: `key_o`=10'h2CA and `key_valid_o`=1 twelve cycles after start; `err_o`=0.
- **Parity fail then retry:**
  - Stimulus: the same frame with parity 0, then the correct frame.
  - Response: `err_o`=1 after the first frame while `key_o` stays 0. After the second frame, `err_o`=0, `key_o`=10'h2CA and `key_valid_o`=1.
- **Lockout:**
  - Stimulus: three bad-parity frames, then a good frame.
  - Response: `locked_o`=1 after the third frame. `key_o` stays 0 and `bit_ready_o` stays 0 through the fourth frame. After `rst`, `locked_o`=0.
- **Abort and stall:**
  - Stimulus: `start_i` after 5 bits. On the restart, drop `bit_valid_i` for 4 cycles mid-frame.
  - Response: the final key reflects only the restarted frame; the fail counter is unchanged.
- **Write-once:**
  - Stimulus: after DONE with 10'h2CA, issue `start_i` plus frame 10'h155 (parity 1).
  - Response: `key_o` stays 10'h2CA and `bit_ready_o` stays 0.
- **Async reset mid-frame:**
  - Stimulus: pulse `rst` between clock edges after 7 bits.
  - Response: all outputs are 0 immediately, before the next edge; the next full frame loads correctly.

Source files
------------

// File: rtl/c432_lock_pkg.sv
// Shared definitions for the c432 key-provisioning path: loader state
// encoding, default key geometry and the frame parity helper.
package c432_lock_pkg;

    localparam int C432_KEY_W     = 10;
    localparam int C432_MAX_FAILS = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_PARITY  = 3'd2,
        ST_DONE    = 3'd3,
        ST_LOCKOUT = 3'd4
    } key_ld_state_t;

    // Even parity over the frame: the running XOR of the key bits combined
    // with the parity bit must be zero for a good frame.
    function automatic logic parity_bad(input logic run_par, input logic p);
        return run_par ^ p;
    endfunction

endpackage

// File: rtl/c432_key_loader.sv
// Bit-serial key loader for the locked c432 core: shifts in KEY_W key bits
// plus an even-parity bit, commits the key once, and locks out after repeated failures.
module c432_key_loader
    import c432_lock_pkg::*;
#(
    parameter int KEY_W     = C432_KEY_W,
    parameter int MAX_FAILS = C432_MAX_FAILS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             bit_ready_o,
    output logic [KEY_W-1:0] key_o,
    output logic             key_valid_o,
    output logic             busy_o,
    output logic             err_o,
    output logic             locked_o
);

    localparam int               CNT_W    = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_W - 1);
    localparam logic [3:0]       FAIL_LIM = 4'(MAX_FAILS);

    key_ld_state_t    state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [KEY_W-1:0] shadow_q, shadow_d;
    logic             par_q,    par_d;
    logic [3:0]       fail_q,   fail_d;
    logic [KEY_W-1:0] key_q,    key_d;
    logic             err_q,    err_d;

    // Next-state logic; start_i outranks a same-cycle bit transfer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        par_d    = par_q;
        fail_d   = fail_q;
        key_d    = key_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = {CNT_W{1'b0}};
                    shadow_d = {KEY_W{1'b0}};
                    par_d    = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (start_i) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = {CNT_W{1'b0}};
                    shadow_d = {KEY_W{1'b0}};
                    par_d    = 1'b0;
                end else if (bit_valid_i) begin
                    shadow_d = shadow_q | (KEY_W'(bit_i) << cnt_q);
                    par_d    = par_q ^ bit_i;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_PARITY: begin
                if (start_i) begin
                    state_d  = ST_SHIFT;
                    cnt_d    = {CNT_W{1'b0}};
                    shadow_d = {KEY_W{1'b0}};
                    par_d    = 1'b0;
                end else if (bit_valid_i) begin
                    cnt_d    = {CNT_W{1'b0}};
                    shadow_d = {KEY_W{1'b0}};
                    par_d    = 1'b0;
                    if (!parity_bad(par_q, bit_i)) begin
                        state_d = ST_DONE;
                        key_d   = shadow_q;
                    end else begin
                        err_d  = 1'b1;
                        fail_d = fail_q + 4'd1;
                        if ((fail_q + 4'd1) == FAIL_LIM) begin
                            state_d = ST_LOCKOUT;
                            key_d   = {KEY_W{1'b0}};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_LOCKOUT: begin
                state_d = ST_LOCKOUT;
                key_d   = {KEY_W{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                key_d   = {KEY_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            shadow_q <= {KEY_W{1'b0}};
            par_q    <= 1'b0;
            fail_q   <= 4'd0;
            key_q    <= {KEY_W{1'b0}};
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            par_q    <= par_d;
            fail_q   <= fail_d;
            key_q    <= key_d;
            err_q    <= err_d;
        end
    end

    assign bit_ready_o = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign busy_o      = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign key_valid_o = (state_q == ST_DONE);
    assign locked_o    = (state_q == ST_LOCKOUT);
    assign key_o       = key_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_c432_key_loader.sv
// Directed bench for c432_key_loader: good frame, parity retry, lockout,
// abort/stall, write-once and asynchronous reset mid-frame.
module tb_c432_key_loader;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       bit_valid_i;
    logic       bit_i;
    logic       bit_ready_o;
    logic [9:0] key_o;
    logic       key_valid_o;
    logic       busy_o;
    logic       err_o;
    logic       locked_o;

    int n_cmp;
    int n_err;

    // Frames are {parity, key}; key bits are sent LSB first.
    localparam logic [10:0] GOOD  = {1'b1, 10'h2CA};
    localparam logic [10:0] BAD   = {1'b0, 10'h2CA};
    localparam logic [10:0] OTHER = {1'b1, 10'h155};

    c432_key_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .bit_valid_i (bit_valid_i),
        .bit_i       (bit_i),
        .bit_ready_o (bit_ready_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .locked_o    (locked_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        start_i     = 1'b0;
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic do_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits, input int stall_at,
                             input int stall_len, input logic exp_rdy, input logic [9:0] exp_key);
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_at) begin
                bit_valid_i = 1'b0;
                for (int s = 0; s < stall_len; s++) step();
            end
            chk("bit_ready", {31'd0, bit_ready_o}, {31'd0, exp_rdy});
            chk("key_hold", {22'd0, key_o}, {22'd0, exp_key});
            bit_valid_i = 1'b1;
            bit_i       = frame[i];
            step();
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic [9:0] k, input logic kv,
                            input logic bz, input logic er, input logic lk);
        chk({tag, ".key"},    {22'd0, key_o},       {22'd0, k});
        chk({tag, ".kvalid"}, {31'd0, key_valid_o}, {31'd0, kv});
        chk({tag, ".busy"},   {31'd0, busy_o},      {31'd0, bz});
        chk({tag, ".ready"},  {31'd0, bit_ready_o}, {31'd0, bz});
        chk({tag, ".err"},    {31'd0, err_o},       {31'd0, er});
        chk({tag, ".locked"}, {31'd0, locked_o},    {31'd0, lk});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // Reset state, then bits in IDLE must be ignored.
        do_reset();
        chk_outs("reset", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        step();
        step();
        step();
        bit_valid_i = 1'b0;
        chk_outs("idle_ign", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Good frame: 1 start edge + 11 transfers = 12 edges to a valid key.
        do_start();
        chk("start.ready", {31'd0, bit_ready_o}, 32'd1);
        send_bits(GOOD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("good", 10'h2CA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Parity failure then retry.
        do_reset();
        do_start();
        send_bits(BAD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("bad1", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        do_start();
        chk("retry.err_clr", {31'd0, err_o}, 32'd0);
        send_bits(GOOD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("retry", 10'h2CA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Lockout after three bad frames; a fourth frame is ignored.
        do_reset();
        do_start();
        send_bits(BAD, 11, -1, 0, 1'b1, 10'h000);
        do_start();
        send_bits(BAD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("lk_two", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        do_start();
        send_bits(BAD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("lk_three", 10'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        do_start();
        send_bits(GOOD, 11, -1, 0, 1'b0, 10'h000);
        chk_outs("lk_fourth", 10'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        do_reset();
        chk_outs("lk_rst", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Two failures, then an aborted frame (start wins over a bit), then a stalled good frame.
        do_start();
        send_bits(BAD, 11, -1, 0, 1'b1, 10'h000);
        do_start();
        send_bits(BAD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("ab_two", 10'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        do_start();
        send_bits(OTHER, 5, -1, 0, 1'b1, 10'h000);
        start_i     = 1'b1;
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        step();
        start_i     = 1'b0;
        bit_valid_i = 1'b0;
        chk("abort.busy", {31'd0, busy_o}, 32'd1);
        send_bits(GOOD, 11, 6, 4, 1'b1, 10'h000);
        chk_outs("abort", 10'h2CA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Write-once: a new frame after DONE is ignored.
        do_start();
        send_bits(OTHER, 11, -1, 0, 1'b0, 10'h2CA);
        chk_outs("wonce", 10'h2CA, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges after 7 bits.
        do_reset();
        do_start();
        send_bits(GOOD, 7, -1, 0, 1'b1, 10'h000);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("async", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst = 1'b0;
        step();
        chk_outs("async_idle", 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        do_start();
        send_bits(GOOD, 11, -1, 0, 1'b1, 10'h000);
        chk_outs("async_reload", 10'h2CA, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
